// File: rtl/tap_pkg.sv
// Shared types and constants for the IEEE 1149.1-style TAP controller.
// State encoding follows the customary 1149.1 assignment, Test-Logic-Reset = 4'hF.
package tap_pkg;

  localparam int IR_W = 2;

  typedef logic [IR_W-1:0] instr_t;

  localparam instr_t INSTR_EXTEST = 2'b00;
  localparam instr_t INSTR_SAMPLE = 2'b01;
  localparam instr_t INSTR_BYPASS = 2'b11;
  localparam instr_t IR_CAPTURE   = 2'b01;

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  // EXTEST and SAMPLE route the scan path through the boundary chain; every other code is bypass.
  function automatic logic is_chain_instr(instr_t i);
    return (i == INSTR_EXTEST) || (i == INSTR_SAMPLE);
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// Test-pin and boundary-chain signal bundle of the TAP controller.
// master = pin/chain side that drives TMS/TDI/ChainTDO, slave = the controller.
interface tap_controller_if;
  import tap_pkg::*;

  logic       TMS;
  logic       TDI;
  logic       ChainTDO;
  logic       ChainTDI;
  logic       ShiftDR;
  logic       ClockDR;
  logic       UpdateDR;
  logic       Mode;
  logic       TDO;
  logic       TDOEn;
  tap_state_t State;

  modport master (
    output TMS, TDI, ChainTDO,
    input  ChainTDI, ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDOEn, State
  );

  modport slave (
    input  TMS, TDI, ChainTDO,
    output ChainTDI, ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDOEn, State
  );

endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP state machine: state register and TMS-driven next-state logic only.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:      state_q <= tms_i ? TLR      : RTI;
        RTI:      state_q <= tms_i ? SEL_DR   : RTI;
        SEL_DR:   state_q <= tms_i ? SEL_IR   : CAP_DR;
        CAP_DR:   state_q <= tms_i ? EX1_DR   : SH_DR;
        SH_DR:    state_q <= tms_i ? EX1_DR   : SH_DR;
        EX1_DR:   state_q <= tms_i ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_q <= tms_i ? EX2_DR   : PAUSE_DR;
        EX2_DR:   state_q <= tms_i ? UPD_DR   : SH_DR;
        UPD_DR:   state_q <= tms_i ? SEL_DR   : RTI;
        SEL_IR:   state_q <= tms_i ? TLR      : CAP_IR;
        CAP_IR:   state_q <= tms_i ? EX1_IR   : SH_IR;
        SH_IR:    state_q <= tms_i ? EX1_IR   : SH_IR;
        EX1_IR:   state_q <= tms_i ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_q <= tms_i ? EX2_IR   : PAUSE_IR;
        EX2_IR:   state_q <= tms_i ? UPD_IR   : SH_IR;
        UPD_IR:   state_q <= tms_i ? SEL_DR   : RTI;
        default:  state_q <= TLR;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_controller.sv
// TAP controller: instruction/bypass registers, boundary-chain control decode and TDO mux.
// All outputs decode registered state, so they are valid in the cycle a state is entered.
module tap_controller
  import tap_pkg::*;
#(
  parameter instr_t RESET_INSTR = INSTR_BYPASS
) (
  input  logic           TCK,
  input  logic           Reset,
  tap_controller_if.slave tap
);

  tap_state_t state_q;
  instr_t     ir_q, ir_d;
  instr_t     irsh_q, irsh_d;
  logic       byp_q, byp_d;
  instr_t     instr_act;
  logic       chain_sel;

  tap_fsm u_fsm (
    .clk     (TCK),
    .rst     (Reset),
    .tms_i   (tap.TMS),
    .state_o (state_q)
  );

  always_comb begin
    ir_d   = ir_q;
    irsh_d = irsh_q;
    byp_d  = byp_q;
    case (state_q)
      TLR:     ir_d   = RESET_INSTR;
      UPD_IR:  ir_d   = irsh_q;
      CAP_IR:  irsh_d = IR_CAPTURE;
      SH_IR:   irsh_d = {tap.TDI, irsh_q[IR_W-1:1]};
      CAP_DR:  byp_d  = 1'b0;
      SH_DR:   byp_d  = tap.TDI;
      default: ;
    endcase
  end

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      ir_q   <= RESET_INSTR;
      irsh_q <= IR_CAPTURE;
      byp_q  <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      irsh_q <= irsh_d;
      byp_q  <= byp_d;
    end
  end

  // Entering TLR must drop Mode at once, even before ir_q reloads on the following edge.
  assign instr_act = (state_q == TLR) ? RESET_INSTR : ir_q;
  assign chain_sel = is_chain_instr(instr_act);

  assign tap.ChainTDI = tap.TDI;
  assign tap.ShiftDR  = chain_sel && (state_q == SH_DR);
  assign tap.ClockDR  = chain_sel && ((state_q == CAP_DR) || (state_q == SH_DR));
  assign tap.UpdateDR = chain_sel && (state_q == UPD_DR);
  assign tap.Mode     = (instr_act == INSTR_EXTEST);
  assign tap.TDOEn    = (state_q == SH_IR) || (state_q == SH_DR);
  assign tap.TDO      = (state_q == SH_IR) ? irsh_q[0] :
                        (state_q == SH_DR) ? (chain_sel ? tap.ChainTDO : byp_q) :
                        1'b0;
  assign tap.State    = state_q;

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1-style TAP controller that sequences the boundary scan chain. Decodes TMS into the 16-state TAP FSM, holds a 2-bit instruction register and a 1-bit bypass register, and drives the chain's ShiftDR/ClockDR/UpdateDR/Mode controls. Muxes the serial return path onto TDO. Sits between the chip's test pins and the boundary scan chain wrapper around the adder/mux core.

## Interface
- IR_W, 2, instruction register width
- RESET_INSTR, 2'b11, instruction loaded on reset or in Test-Logic-Reset (BYPASS)
- TCK  in  1  sole clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; forces Test-Logic-Reset
- TMS  in  1  TAP mode select, sampled on rising TCK
- TDI  in  1  serial data in, sampled on rising TCK
- ChainTDO  in  1  serial out of boundary scan chain
- ChainTDI  out  1  serial in to chain (= TDI)
- ShiftDR  out  1  chain shift select
- ClockDR  out  1  chain capture/shift clock enable (gated externally by a clock-gating cell)
- UpdateDR  out  1  chain update strobe, one TCK cycle
- Mode  out  1  chain output-mux select (1 = boundary cells drive pins)
- TDO  out  1  serial data out
- TDOEn  out  1  TDO output enable
- State  out  4  current TAP state, for debug/verification

## Operation
- FSM states: TestLogicReset, RunTestIdle, SelectDRScan, CaptureDR, ShiftDR, Exit1DR, PauseDR, Exit2DR, UpdateDR, SelectIRScan, CaptureIR, ShiftIR, Exit1IR, PauseIR, Exit2IR, UpdateIR.
- Transitions (TMS=0 / TMS=1): TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; CapDR→ShDR/Ex1DR; ShDR→ShDR/Ex1DR; Ex1DR→PauseDR/UpdDR; PauseDR→PauseDR/Ex2DR; Ex2DR→ShDR/UpdDR; UpdDR→RTI/SelDR; SelIR→CapIR/TLR; IR branch mirrors DR; UpdIR→RTI/SelDR.
- Instructions: 2'b00 EXTEST, 2'b01 SAMPLE, 2'b10 and 2'b11 BYPASS.
- IR shift register: CaptureIR loads 2'b01; ShiftIR shifts right, TDI into MSB, LSB to TDO. Active instruction register loads shift register on the edge leaving UpdateIR; loads RESET_INSTR whenever state is TLR.
- Chain selected when active instruction is EXTEST or SAMPLE; otherwise bypass selected.
- Bypass: CaptureDR loads 0; ShiftDR loads TDI.
- ShiftDR = 1 in ShiftDR state and chain selected.
- ClockDR = 1 in CaptureDR or ShiftDR state and chain selected.
- UpdateDR = 1 in UpdateDR state and chain selected.
- Mode = 1 when active instruction is EXTEST.
- TDO mux: ShiftIR → IR shift LSB; ShiftDR → ChainTDO if chain selected else bypass bit; otherwise 0. TDOEn = 1 only in ShiftIR/ShiftDR.

## Timing
- Reset (async, immediate): State=TLR, active IR=BYPASS, IR shift=2'b01, bypass=0; ShiftDR=ClockDR=UpdateDR=Mode=TDO=TDOEn=0.
- Reset mid-scan aborts the scan; no UpdateDR pulse; chain contents undefined, Mode drops same instant.
- Control outputs decode the registered state: valid in the cycle the state is entered, no extra latency.
- Five consecutive TMS=1 edges reach TLR from any state.
- Mode/chain select change one TCK after UpdateIR (on edge leaving it); ShiftIR→Exit1IR→UpdateIR with no pause gives new instruction in RTI.
- PauseDR/PauseIR: all strobes 0, shift registers hold.
- N-bit DR scan: CaptureDR (1 ClockDR), N ShiftDR cycles, Exit1DR, UpdateDR (1 pulse).

## Structure
- Package tap_pkg: tap_state_t enum (4-bit encoding, TLR=4'hF), IR_W, instruction constants EXTEST/SAMPLE/BYPASS, IR capture value 2'b01.
- Sub-module tap_fsm: state register plus next-state logic only; tap_controller instantiates it and holds IR, bypass, output decode, TDO mux.

## Test plan
- Reset asserted mid-ShiftDR → State=TLR immediately, all outputs 0, Mode=0, active IR=2'b11.
- From RTI, TMS 1,1,0,0 then shift IR 2'b00 (TMS 0,1), TMS 1,0 → TDO returns 1,0 (capture 2'b01); Mode=1 one cycle after UpdateIR.
- EXTEST active, DR scan of 51 bits → ClockDR high 52 cycles (capture+51 shifts), ShiftDR high 51, single UpdateDR pulse; TDO equals ChainTDO throughout shift.
- BYPASS active, shift TDI=1,0,1,1 → TDO=0,1,0,1 (1-cycle delay, leading 0); ShiftDR/ClockDR/UpdateDR stay 0.
- From every state, TMS=1 for 5 edges → State=TLR, active IR=BYPASS, Mode=0.
- ShiftDR→Exit1DR→PauseDR (3 cycles)→Exit2DR→ShiftDR → ClockDR=0 during pause, shifting resumes with no lost bit.
